// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port RAM16K-style data memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.

`timescale 1ns / 1ps

module mem_arbiter #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              busy,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic grant_sel;

    assign any_req = req0 | req1;

`ifdef MEM_ARB_RR_EN
    // last_q = 1 means port 1 was served last, so port 0 wins the next tie.
    logic last_q, last_d;

    always_comb begin
        grant_sel = req1;
        if (req0 && req1) begin
            grant_sel = ~last_q;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = grant_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Port 0 wins every tie.
    always_comb begin
        grant_sel = ~req0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    owner_d = grant_sel;
                    if (grant_sel) begin
                        we_d    = we1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                    end else begin
                        we_d    = we0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = ram_out;
                    end else begin
                        rdata0_d = ram_out;
                    end
                end
            end
            StResp: begin
                // Requests are deliberately ignored here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        ack0        = (state_q == StResp) && !owner_q;
        ack1        = (state_q == StResp) && owner_q;
        busy        = (state_q != StIdle);
        ram_load    = (state_q == StAccess) && we_q;
        ram_address = addr_q;
        ram_in      = wdata_q;
        rdata0      = rdata0_q;
        rdata1      = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue each transaction, a negedge monitor
// checks every cycle against a grant-time arithmetic model and a shadow memory.

`timescale 1ns / 1ps

module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req   = 2'b00;
    logic [1:0]    we    = 2'b00;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          ack0, ack1, busy, ram_load;
    logic [DW-1:0] rdata0, rdata1, ram_in, ram_out;
    logic [AW-1:0] ram_address;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req[0]),
        .we0         (we[0]),
        .addr0       (addr[0]),
        .wdata0      (wdata[0]),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .req1        (req[1]),
        .we1         (we[1]),
        .addr1       (addr[1]),
        .wdata1      (wdata[1]),
        .ack1        (ack1),
        .rdata1      (rdata1),
        .busy        (busy),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    // RAM16K behaviour: combinational read, write on rising edge.
    always @(posedge clock) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    txn_t          q0[$], q1[$];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            mon_en = 1'b0;
    bit            own;
    bit            last_served = 1'b1;
    txn_t          cur;
    int            cyc = 0;
    int            lg  = -100;  // cycle in which the model last granted
    int            dlt;
    bit            win;

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            cyc++;
            dlt = cyc - lg;
            if (dlt == 2) begin
                if (own) begin
                    if (q1.size() > 0) void'(q1.pop_front());
                end else begin
                    if (q0.size() > 0) void'(q0.pop_front());
                end
                if (cur.we) shadow[cur.addr] = cur.wdata;
                else exp_rd[own] = shadow_rd(cur.addr);
            end
            check("ack0", ack0, (dlt == 2) && !own);
            check("ack1", ack1, (dlt == 2) && own);
            check("busy", busy, (dlt == 1) || (dlt == 2));
            check("ram_load", ram_load, (dlt == 1) && cur.we);
            check("ram_address", ram_address, exp_addr);
            check("ram_in", ram_in, exp_wdata);
            check("rdata0", rdata0, exp_rd[0]);
            check("rdata1", rdata1, exp_rd[1]);

            if (dlt >= 3 && (req[0] || req[1])) begin
                win = req[0] ? 1'b0 : 1'b1;
`ifdef MEM_ARB_RR_EN
                if (req[0] && req[1]) win = last_served ? 1'b0 : 1'b1;
`endif
                if ((win ? q1.size() : q0.size()) == 0) begin
                    check("grant_queue_empty", 1, 0);
                end else begin
                    cur         = win ? q1[0] : q0[0];
                    own         = win;
                    last_served = win;
                    lg          = cyc;
                    exp_addr    = cur.addr;
                    exp_wdata   = cur.wdata;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [AW-1:0] pool [8];

    task automatic do_txn(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] dv);
        txn_t t;
        int   k;
        @(posedge clock);
        #1;
        req[p] = 1'b1;
        we[p] = w;
        addr[p] = a;
        wdata[p] = dv;
        t.we = w;
        t.addr = a;
        t.wdata = dv;
        if (p == 0) q0.push_back(t);
        else q1.push_back(t);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(p == 0 ? ack0 : ack1) && k < 300);
        if (k >= 300) check($sformatf("ack%0d_timeout", p), 0, 1);
    endtask

    task automatic release_port(input int p);
        @(posedge clock);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic txn_once(input int p, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] dv);
        do_txn(p, w, a, dv);
        release_port(p);
    endtask

    task automatic rand_port(input int p, input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            do_txn(p, 1'($urandom_range(1, 0)), pool[$urandom_range(7, 0)], 16'($urandom));
            gap = $urandom_range(2, 0);
            if (gap > 0) begin
                release_port(p);
                repeat (gap - 1) @(posedge clock);
            end
        end
        release_port(p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        pool = '{14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0005, 14'h0010, 14'h3FFF,
                 14'h2000};
        addr[0] = '0;
        addr[1] = '0;
        wdata[0] = '0;
        wdata[1] = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_addr = '0;
        exp_wdata = '0;
        cur.we = 1'b0;
        cur.addr = '0;
        cur.wdata = '0;
        own = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_load", ram_load, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        mon_en = 1'b1;

        // Idle stretch: the monitor expects busy/ack/ram_load low throughout.
        repeat (20) @(posedge clock);

        txn_once(0, 1'b1, 14'h0005, 16'hBEEF);
        txn_once(0, 1'b0, 14'h0005, 16'h0000);
        check("read_back_0005", rdata0, 16'hBEEF);

        // Two simultaneous collisions.
        for (int r = 0; r < 2; r++) begin
            fork
                txn_once(0, 1'b0, 14'h0001, 16'h0000);
                txn_once(1, 1'b0, 14'h0002, 16'h0000);
            join
        end

        txn_once(1, 1'b1, 14'h3FFF, 16'h1234);
        txn_once(0, 1'b0, 14'h3FFF, 16'h0000);
        check("cross_port_rdata0", rdata0, 16'h1234);

        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (4) @(posedge clock);

        // Reset during the ACCESS cycle of a write.
        mon_en = 1'b0;
        @(posedge clock);
        #1;
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[0] = 14'h0010;
        wdata[0] = 16'hA5A5;
        @(posedge clock);
        #1;
        check("racc_ram_load", ram_load, 1);
        check("racc_busy", busy, 1);
        reset = 1'b1;
        req[0] = 1'b0;
        @(negedge clock);
        check("racc_ack0", ack0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("racc_ack0_after", ack0, 0);
        check("racc_ack1_after", ack1, 0);
        check("racc_busy_after", busy, 0);
        check("racc_ram_load_after", ram_load, 0);
        check("racc_ram_address_after", ram_address, 0);
        check("racc_ram_in_after", ram_in, 0);
        check("racc_rdata0_after", rdata0, 0);
        check("racc_rdata1_after", rdata1, 0);

        q0.delete();
        q1.delete();
        shadow[14'h0010] = 16'hA5A5;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_addr = '0;
        exp_wdata = '0;
        cur.we = 1'b0;
        last_served = 1'b1;
        lg = cyc - 10;
        mon_en = 1'b1;

        txn_once(0, 1'b0, 14'h0010, 16'h0000);
        check("post_reset_read_0010", rdata0, 16'hA5A5);
        repeat (3) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
